// File: rtl/spm_pkg.sv
// Shared types and defaults for the spm operand sequencer and its deserialiser.
// No logic, no latency: state encoding, default widths and the counter-width helper.
// No handshakes of its own.
`timescale 1ns/1ps
package spm_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int PW_DEF    = 2 * WIDTH_DEF;
    localparam int LAT_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        SHIFT,
        DONE
    } state_t;

    // Counter must reach PW+LAT-1, so size it for PW+LAT values.
    function automatic int cnt_width(input int pw, input int lat);
        return $clog2(pw + lat + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(PW_DEF, LAT_DEF);
endpackage

// File: rtl/spm.sv
// Serial-parallel multiplier: parallel two's-complement x, serial y LSB first, serial p.
// Latency: product bit k is on p one cycle after y bit k is presented.
// No backpressure; rst (synchronous, active-high) clears the carry/sum state.
`timescale 1ns/1ps
module spm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic             y,
    output logic             p
);
    logic [WIDTH:0]   r_acc;
    logic [WIDTH+1:0] w_sum;

    // Sign-extending x makes the MSB term count negatively.
    always_comb begin
        w_sum = {r_acc[WIDTH], r_acc} + (y ? {{2{x[WIDTH-1]}}, x} : {(WIDTH+2){1'b0}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            p     <= 1'b0;
        end else begin
            p     <= w_sum[0];
            r_acc <= w_sum[WIDTH+1:1];
        end
    end
endmodule

// File: rtl/spm_deser.sv
// LSB-first serial-in/parallel-out register for the spm product stream.
// Latency: one bit per enabled cycle; the first bit shifted in ends up at bit 0.
// No backpressure; holds its value whenever en is low.
`timescale 1ns/1ps
module spm_deser
    import spm_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          din,
    output logic [PW-1:0] dout
);
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (en) begin
            dout <= {din, dout[PW-1:1]};
        end
    end
endmodule

// File: rtl/spm_seq.sv
// Operand sequencer/product collector around spm; SPM_SEQ_SIGNED_EN sign-extends in_mp.
// Latency: out_valid rises PW+LAT+2 cycles after the accept edge; one operation in flight.
// Backpressure: DONE holds out_valid/out_prod until out_ready; in_ready is low whenever busy.
`timescale 1ns/1ps
module spm_seq
    import spm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PW    = 2 * WIDTH,
    parameter int LAT   = LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mc,
    input  logic [WIDTH-1:0] in_mp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_prod,
    output logic             busy,
    output logic             spm_clr,
    output logic [WIDTH-1:0] spm_x,
    output logic             spm_y,
    input  logic             spm_p
);
    localparam int            CW   = cnt_width(PW, LAT);
    localparam logic [CW-1:0] LAST = CW'(PW + LAT - 1);
    localparam logic [CW-1:0] LATC = CW'(LAT);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_ext;
    logic [PW-1:0] w_ext_in;
    logic          w_shift_en;

`ifdef SPM_SEQ_SIGNED_EN
    assign w_ext_in = {{(PW-WIDTH){in_mp[WIDTH-1]}}, in_mp};
`else
    assign w_ext_in = {{(PW-WIDTH){1'b0}}, in_mp};
`endif

    // Bit k of the product appears LAT cycles after y bit k was driven.
    assign w_shift_en = (r_state == SHIFT) && (r_cnt >= LATC);

    spm_deser #(
        .PW(PW)
    ) u_deser (
        .clk  (clk),
        .rst  (rst),
        .en   (w_shift_en),
        .din  (spm_p),
        .dout (out_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ext     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            spm_clr   <= 1'b1;
            spm_x     <= '0;
            spm_y     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        spm_x    <= in_mc;
                        r_ext    <= w_ext_in;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        spm_clr  <= 1'b1;
                        spm_y    <= 1'b0;
                        r_state  <= CLR;
                    end
                end
                CLR: begin
                    // spm_y is registered, so preload bit 0 for the first SHIFT cycle.
                    spm_clr <= 1'b0;
                    spm_y   <= r_ext[0];
                    r_ext   <= {1'b0, r_ext[PW-1:1]};
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    spm_y <= r_ext[0];
                    r_ext <= {1'b0, r_ext[PW-1:1]};
                    if (r_cnt == LAST) begin
                        spm_clr <= 1'b1;
                        spm_y   <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/spm_seq.md
Name: spm_seq

Overview:
- Operand sequencer and product collector wrapped around the serial-parallel multiplier (spm).
- Accepts a parallel multiplicand/multiplier pair over a valid/ready handshake.
- Drives spm's parallel x and its serial y (LSB first, extended to the full product width), then deserialises spm's serial p into a parallel product.
- Sits between the register-level datapath and the spm instance: feeds it and consumes its output.

Parameters:
- WIDTH, 8, operand width; must match the spm x width.
- PW, 2*WIDTH, product width and number of serial y bits driven.
- LAT, 1, clock cycles from presenting y bit k on spm_y to product bit k being valid on spm_p.

Ports:
- clk  input  1  rising-edge clock, shared with spm.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_mc  input  WIDTH  multiplicand; always two's complement (spm negates the MSB term).
- in_mp  input  WIDTH  multiplier; serialised onto spm_y.
- out_valid  output  1  product valid; held until consumed.
- out_ready  input  1  consumer accepts the product.
- out_prod  output  PW  product.
- busy  output  1  high in every state except IDLE.
- spm_clr  output  1  clear pulse to the spm rst input.
- spm_x  output  WIDTH  parallel operand to spm.
- spm_y  output  1  serial operand to spm.
- spm_p  input  1  serial product bit from spm.

Behaviour:
- All outputs are registered. Reset is synchronous.
- Reset values: in_ready=1, out_valid=0, out_prod=0, busy=0, spm_clr=1 (holds spm clear during reset), spm_x=0, spm_y=0. State=IDLE, cnt=0.
- States:
  - IDLE: in_ready=1. On the edge where in_valid&&in_ready:
    - capture in_mc into spm_x and the extended multiplier into a PW-bit shift register;
    - in_ready goes to 0 and busy goes to 1;
    - go to CLR.
  - CLR: one cycle with spm_clr=1, spm_y=0; clears the spm carry/sum flops. Go to SHIFT with cnt=0.
  - SHIFT: spm_clr=0.
    - spm_y = ext[cnt] for cnt<PW, 0 for cnt>=PW.
    - When cnt>=LAT, shift spm_p into out_prod bit (cnt-LAT), LSB first.
    - cnt runs 0..PW+LAT-1; at the final count go to DONE.
  - DONE: out_valid=1, out_prod stable. On out_valid&&out_ready go to IDLE: out_valid goes to 0, in_ready goes to 1, busy goes to 0.
- Latency: out_valid first high PW+LAT+2 cycles after the accept edge (19 with defaults).
- spm_x is held constant from accept until DONE exits.
- Product width: the result is truncated to PW bits. Overflow cannot occur for the supported operand ranges.
- No overlap: in_ready is 0 outside IDLE, so a new operand is accepted at the earliest one cycle after the output handshake.
- Backpressure: DONE may persist indefinitely; out_prod must not change while out_valid=1.
- Reset mid-operation, in any state: next cycle is IDLE, all outputs at reset values, the partial product is discarded, and spm_clr=1 for the reset cycle.
- in_valid while busy is ignored; nothing is queued.

Optional Feature:
- Macro: SPM_SEQ_SIGNED_EN.
- Defined: in_mp is two's complement; ext bits [PW-1:WIDTH] = in_mp[WIDTH-1] (sign extension). The product is signed×signed.
- Undefined: ext bits [PW-1:WIDTH] = 0; in_mp is unsigned. The product is signed(mc)×unsigned(mp).
- The only difference between the two builds is the extension logic.

Decomposition:
- Shared package spm_pkg:
  - state encoding typedef: IDLE, CLR, SHIFT, DONE;
  - localparams for WIDTH, PW and LAT defaults;
  - count width, $clog2(PW+LAT+1).
- One natural sub-module: spm_deser, a PW-bit LSB-first serial-in/parallel-out register with enable.
- Operand capture and the FSM stay in spm_seq.
- The bench top instantiates spm_seq plus spm, with spm_clr connected to spm.rst.

Test Plan:
- Reset, then mc=0x03, mp=0x05, out_ready=1 (either build) -> out_prod=0x000F; out_valid high exactly 19 cycles after accept.
- Macro undefined: mc=0xFF, mp=0xFF -> out_prod=0xFF01 (-1×255). Macro defined: same inputs -> out_prod=0x0001.
- Macro defined: mc=0x80, mp=0x80 -> 0x4000. mc=0x7F, mp=0x80 -> 0xC080.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_prod stable, in_ready=0, a second in_valid is ignored. Then out_ready=1 -> back to IDLE, next op accepted one cycle later.
- Assert rst during SHIFT at cnt=7 -> next cycle all outputs at reset values. A following op mc=0x02, mp=0x03 -> 0x0006, with no contamination from the aborted op.
- Back-to-back random: 1000 operand pairs with random in_valid/out_ready gaps -> every product matches the reference model for the active build.
